prio_demux_router: RTL

- Streaming 1-to-4 router; the counterpart of the team's 4-input priority selector.
- Takes one input stream with a 4-bit select mask and delivers each beat to exactly one of four output ports.
- The destination is the highest-priority set select bit, and each output port has a one-entry register buffer with valid/ready handshake.
- Sits between a single producer and four consumer lanes. Unroutable beats (mask zero) are consumed, discarded and counted.

---
 rtl/prio_demux_router.sv | 96 +++++++++
 1 files changed

// File: rtl/prio_demux_router.sv
// Streaming 1-to-4 priority demux: each beat goes to the port named by the highest set
// bit of s_sel. Each port has a one-entry buffer. Optional broadcast: PRIO_ROUTER_BCAST_EN.
module prio_demux_router #(
    parameter int DW    = 4,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [3:0]      s_sel,
    input  logic [DW-1:0]   s_data,
    output logic [3:0]      m_valid,
    input  logic [3:0]      m_ready,
    output logic [4*DW-1:0] m_data,
    output logic [CNT_W-1:0] drop_cnt
);

    // Handshake: a beat moves when valid && ready on the same rising edge. s_ready never
    // looks at s_valid, and a loaded m_valid stays up with stable data until m_ready.
    logic [3:0]       r_valid;
    logic [4*DW-1:0]  r_data;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [1:0] w_tgt;
    logic [3:0] w_tgt_oh;
    logic       w_drop;
    logic       w_bcast;
    logic [3:0] w_free;
    logic [3:0] w_load;
    logic       w_accept;

    always_comb begin
        w_tgt  = 2'd0;
        w_drop = 1'b0;
        casez (s_sel)
            4'b1???: w_tgt = 2'd3;
            4'b01??: w_tgt = 2'd2;
            4'b001?: w_tgt = 2'd1;
            4'b0001: w_tgt = 2'd0;
            default: w_drop = 1'b1;
        endcase
    end

    assign w_tgt_oh = 4'b0001 << w_tgt;
    assign w_free   = ~r_valid | m_ready;

`ifdef PRIO_ROUTER_BCAST_EN
    assign w_bcast = (s_sel == 4'b1111);
`else
    assign w_bcast = 1'b0;
`endif

    always_comb begin
        if (w_drop) begin
            s_ready = 1'b1;
        end else if (w_bcast) begin
            s_ready = &w_free;
        end else begin
            s_ready = w_free[w_tgt];
        end
    end

    assign w_accept = s_valid && s_ready;
    assign w_load   = (w_accept && !w_drop) ? (w_bcast ? 4'b1111 : w_tgt_oh) : 4'b0000;

    // A port refilled in the same cycle it drains stays valid and takes the new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_load[i]) begin
                    r_valid[i]         <= 1'b1;
                    r_data[i*DW +: DW] <= s_data;
                end else if (m_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign m_valid  = r_valid;
    assign m_data   = r_data;
    assign drop_cnt = r_drop_cnt;

endmodule
